// File: rtl/fpu_tag_rob.sv
// fpu_tag_rob
//   Reorder buffer in front of the ray-plane intersection FPU slices.
//   Hands out tags in allocation order. The FMA, DIV and CMP slices return
//   tagged results out of order, and the block retires them in allocation
//   order.
//
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   alloc_valid_i / alloc_ready_o       tag request handshake
//   alloc_tag_o                         tag granted on the handshake
//   {fma,div,cmp}_{valid,tag,result,status}_i
//                                       result write ports (always accepted)
//   ret_valid_o / ret_ready_i           in-order retire handshake
//   ret_tag_o, ret_result_o, ret_status_o
//                                       head entry, zero when not valid
//   count_o                             occupied entries
//   err_o                               one-cycle pulse after an illegal write
module fpu_tag_rob #(
  parameter int Depth       = 32,
  parameter int DataWidth   = 32,
  parameter int StatusWidth = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  output logic [4:0]             alloc_tag_o,
  input  logic                   fma_valid_i,
  input  logic [4:0]             fma_tag_i,
  input  logic [DataWidth-1:0]   fma_result_i,
  input  logic [StatusWidth-1:0] fma_status_i,
  input  logic                   div_valid_i,
  input  logic [4:0]             div_tag_i,
  input  logic [DataWidth-1:0]   div_result_i,
  input  logic [StatusWidth-1:0] div_status_i,
  input  logic                   cmp_valid_i,
  input  logic [4:0]             cmp_tag_i,
  input  logic [DataWidth-1:0]   cmp_result_i,
  input  logic [StatusWidth-1:0] cmp_status_i,
  output logic                   ret_valid_o,
  input  logic                   ret_ready_i,
  output logic [4:0]             ret_tag_o,
  output logic [DataWidth-1:0]   ret_result_o,
  output logic [StatusWidth-1:0] ret_status_o,
  output logic [5:0]             count_o,
  output logic                   err_o
);

  localparam int AW      = $clog2(Depth);
  localparam int NPorts  = 3;  // index order is write priority: FMA, DIV, CMP

  typedef logic [AW-1:0] idx_t;

  idx_t                   head_q, tail_q;
  logic [5:0]             count_q;
  logic [Depth-1:0]       pending_q, done_q;
  logic [Depth-1:0]       pending_d, done_d;
  logic                   err_q;
  logic [DataWidth-1:0]   result_q [Depth];
  logic [StatusWidth-1:0] status_q [Depth];

  // Result ports gathered into arrays so priority and legality are one loop.
  logic [NPorts-1:0]      wr_valid;
  logic [4:0]             wr_tag    [NPorts];
  logic [DataWidth-1:0]   wr_result [NPorts];
  logic [StatusWidth-1:0] wr_status [NPorts];
  idx_t                   wr_idx    [NPorts];
  logic [NPorts-1:0]      wr_in_range, wr_coll, wr_ok;

  logic alloc_fire, ret_fire, err_d;

  assign wr_valid     = {cmp_valid_i, div_valid_i, fma_valid_i};
  assign wr_tag[0]    = fma_tag_i;
  assign wr_tag[1]    = div_tag_i;
  assign wr_tag[2]    = cmp_tag_i;
  assign wr_result[0] = fma_result_i;
  assign wr_result[1] = div_result_i;
  assign wr_result[2] = cmp_result_i;
  assign wr_status[0] = fma_status_i;
  assign wr_status[1] = div_status_i;
  assign wr_status[2] = cmp_status_i;

  // Both flags come from registered state only, so a retire in a full cycle
  // does not open allocation until the next cycle.
  assign alloc_ready_o = (count_q != 6'(Depth));
  assign alloc_tag_o   = 5'(tail_q);
  assign ret_valid_o   = (count_q != 6'd0) && done_q[head_q];
  assign ret_tag_o     = ret_valid_o ? 5'(head_q) : 5'd0;
  assign ret_result_o  = ret_valid_o ? result_q[head_q] : '0;
  assign ret_status_o  = ret_valid_o ? status_q[head_q] : '0;
  assign count_o       = count_q;
  assign err_o         = err_q;

  assign alloc_fire = alloc_valid_i && alloc_ready_o;
  assign ret_fire   = ret_valid_o && ret_ready_i;

  // Write legality: the tag must be in range, allocated and not yet done.
  // A port that shares its tag with a higher-priority valid port is dropped.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first so that no path can infer a latch.
  always_comb begin
    wr_coll     = '0;
    wr_ok       = '0;
    wr_in_range = '0;
    err_d       = 1'b0;
    for (int p = 0; p < NPorts; p++) begin
      wr_idx[p]      = wr_tag[p][AW-1:0];
      wr_in_range[p] = (int'(wr_tag[p]) < Depth);
      for (int q = 0; q < p; q++) begin
        if (wr_valid[q] && (wr_tag[q] == wr_tag[p])) wr_coll[p] = 1'b1;
      end
      wr_ok[p] = wr_valid[p] && !wr_coll[p] && wr_in_range[p] &&
                 pending_q[wr_idx[p]] && !done_q[wr_idx[p]];
      if (wr_valid[p] && !wr_ok[p]) err_d = 1'b1;
    end
  end

  // Entry flags. The tail slot is never pending while not full and the
  // head slot is already done, so alloc, writes and retire never collide.
  always_comb begin
    pending_d = pending_q;
    done_d    = done_q;
    if (alloc_fire) begin
      pending_d[tail_q] = 1'b1;
      done_d[tail_q]    = 1'b0;
    end
    for (int p = 0; p < NPorts; p++) begin
      if (wr_ok[p]) done_d[wr_idx[p]] = 1'b1;
    end
    if (ret_fire) begin
      pending_d[head_q] = 1'b0;
      done_d[head_q]    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (alloc_fire) tail_q <= tail_q + idx_t'(1);
      if (ret_fire)   head_q <= head_q + idx_t'(1);
      if (alloc_fire && !ret_fire)      count_q <= count_q + 6'd1;
      else if (!alloc_fire && ret_fire) count_q <= count_q - 6'd1;
    end
  end

  // NOTE: the payload storage has no reset; done_q gates every read, and the
  // retire outputs are forced to zero whenever the head entry is not valid.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NPorts; p++) begin
      if (wr_ok[p]) begin
        result_q[wr_idx[p]] <= wr_result[p];
        status_q[wr_idx[p]] <= wr_status[p];
      end
    end
  end

endmodule

// File: tb/tb_fpu_tag_rob.sv
// Directed testbench for fpu_tag_rob (Depth 32, 32-bit results, 5-bit flags).
// Inputs change 1 time unit after each rising edge, and outputs are checked
// before the following edge.
module tb_fpu_tag_rob;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        alloc_valid_i, alloc_ready_o;
  logic [4:0]  alloc_tag_o;
  logic        fma_valid_i, div_valid_i, cmp_valid_i;
  logic [4:0]  fma_tag_i, div_tag_i, cmp_tag_i;
  logic [31:0] fma_result_i, div_result_i, cmp_result_i;
  logic [4:0]  fma_status_i, div_status_i, cmp_status_i;
  logic        ret_valid_o, ret_ready_i;
  logic [4:0]  ret_tag_o;
  logic [31:0] ret_result_o;
  logic [4:0]  ret_status_o;
  logic [5:0]  count_o;
  logic        err_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  fpu_tag_rob #(.Depth(32), .DataWidth(32), .StatusWidth(5)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alloc_valid_i(alloc_valid_i),
    .alloc_ready_o(alloc_ready_o),
    .alloc_tag_o  (alloc_tag_o),
    .fma_valid_i  (fma_valid_i),
    .fma_tag_i    (fma_tag_i),
    .fma_result_i (fma_result_i),
    .fma_status_i (fma_status_i),
    .div_valid_i  (div_valid_i),
    .div_tag_i    (div_tag_i),
    .div_result_i (div_result_i),
    .div_status_i (div_status_i),
    .cmp_valid_i  (cmp_valid_i),
    .cmp_tag_i    (cmp_tag_i),
    .cmp_result_i (cmp_result_i),
    .cmp_status_i (cmp_status_i),
    .ret_valid_o  (ret_valid_o),
    .ret_ready_i  (ret_ready_i),
    .ret_tag_o    (ret_tag_o),
    .ret_result_o (ret_result_o),
    .ret_status_o (ret_status_o),
    .count_o      (count_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid_i = 1'b0;
    ret_ready_i   = 1'b0;
    fma_valid_i   = 1'b0; fma_tag_i = '0; fma_result_i = '0; fma_status_i = '0;
    div_valid_i   = 1'b0; div_tag_i = '0; div_result_i = '0; div_status_i = '0;
    cmp_valid_i   = 1'b0; cmp_tag_i = '0; cmp_result_i = '0; cmp_status_i = '0;
  endtask

  // Short reset pulse between edges, called just after tick().
  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    alloc_valid_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    alloc_valid_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    #2;
    check("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
    check("rst_alloc_tag",   64'(alloc_tag_o),   64'd0);
    check("rst_ret_valid",   64'(ret_valid_o),   64'd0);
    check("rst_ret_tag",     64'(ret_tag_o),     64'd0);
    check("rst_ret_result",  64'(ret_result_o),  64'd0);
    check("rst_ret_status",  64'(ret_status_o),  64'd0);
    check("rst_count",       64'(count_o),       64'd0);
    check("rst_err",         64'(err_o),         64'd0);
    #10 rst_ni = 1'b1;
    tick();

    // ---- in-order single CMP op ----
    alloc_valid_i = 1'b1;
    check("t1_alloc_tag", 64'(alloc_tag_o), 64'd0);
    tick();
    alloc_valid_i = 1'b0;
    cmp_valid_i = 1'b1; cmp_tag_i = 5'd0; cmp_result_i = 32'h3F80_0000;
    check("t1_count_1",   64'(count_o),     64'd1);
    check("t1_no_bypass", 64'(ret_valid_o), 64'd0);
    tick();
    cmp_valid_i = 1'b0;
    check("t1_ret_valid",  64'(ret_valid_o),  64'd1);
    check("t1_ret_tag",    64'(ret_tag_o),    64'd0);
    check("t1_ret_result", 64'(ret_result_o), 64'h3F80_0000);
    check("t1_err",        64'(err_o),        64'd0);
    ret_ready_i = 1'b1;
    tick();
    ret_ready_i = 1'b0;
    check("t1_count_0",    64'(count_o),     64'd0);
    check("t1_ret_idle",   64'(ret_valid_o), 64'd0);

    // ---- out-of-order completion, in-order retire ----
    do_reset();
    tick();
    alloc_n(3);
    check("t2_count_3", 64'(count_o), 64'd3);
    cmp_valid_i = 1'b1; cmp_tag_i = 5'd2; cmp_result_i = 32'hA2; cmp_status_i = 5'd1;
    tick();
    cmp_valid_i = 1'b0;
    check("t2_wait_a", 64'(ret_valid_o), 64'd0);
    fma_valid_i = 1'b1; fma_tag_i = 5'd1; fma_result_i = 32'hA1; fma_status_i = 5'd2;
    tick();
    fma_valid_i = 1'b0;
    check("t2_wait_b", 64'(ret_valid_o), 64'd0);
    div_valid_i = 1'b1; div_tag_i = 5'd0; div_result_i = 32'hA0; div_status_i = 5'd4;
    tick();
    div_valid_i = 1'b0;
    check("t2_r0_valid",  64'(ret_valid_o),  64'd1);
    check("t2_r0_tag",    64'(ret_tag_o),    64'd0);
    check("t2_r0_result", 64'(ret_result_o), 64'hA0);
    check("t2_r0_status", 64'(ret_status_o), 64'd4);
    ret_ready_i = 1'b1;
    tick();
    check("t2_r1_tag",    64'(ret_tag_o),    64'd1);
    check("t2_r1_result", 64'(ret_result_o), 64'hA1);
    check("t2_r1_status", 64'(ret_status_o), 64'd2);
    tick();
    check("t2_r2_tag",    64'(ret_tag_o),    64'd2);
    check("t2_r2_result", 64'(ret_result_o), 64'hA2);
    check("t2_r2_status", 64'(ret_status_o), 64'd1);
    tick();
    ret_ready_i = 1'b0;
    check("t2_drained", 64'(ret_valid_o), 64'd0);
    check("t2_count_0", 64'(count_o),     64'd0);
    check("t2_err",     64'(err_o),       64'd0);

    // ---- full buffer, backpressure, wrap ----
    do_reset();
    tick();
    alloc_valid_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("t3_alloc_tag_%0d", i), 64'(alloc_tag_o), 64'(i));
      tick();
    end
    alloc_valid_i = 1'b0;
    check("t3_full_ready", 64'(alloc_ready_o), 64'd0);
    check("t3_full_count", 64'(count_o),       64'd32);
    fma_valid_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      fma_tag_i = 5'(i); fma_result_i = 32'h1000 + 32'(i);
      tick();
    end
    fma_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_hold_valid_%0d", k),  64'(ret_valid_o),  64'd1);
      check($sformatf("t3_hold_tag_%0d", k),    64'(ret_tag_o),    64'd0);
      check($sformatf("t3_hold_result_%0d", k), 64'(ret_result_o), 64'h1000);
      tick();
    end
    alloc_valid_i = 1'b1; ret_ready_i = 1'b1;
    check("t3_full_retire_ready", 64'(alloc_ready_o), 64'd0);
    tick();
    ret_ready_i = 1'b0;
    check("t3_count_31",   64'(count_o),       64'd31);
    check("t3_ready_back", 64'(alloc_ready_o), 64'd1);
    check("t3_wrap_tag",   64'(alloc_tag_o),   64'd0);
    check("t3_next_tag",   64'(ret_tag_o),     64'd1);
    check("t3_next_res",   64'(ret_result_o),  64'h1001);
    tick();
    alloc_valid_i = 1'b0;
    check("t3_refull_count", 64'(count_o),       64'd32);
    check("t3_refull_ready", 64'(alloc_ready_o), 64'd0);
    check("t3_refull_tag",   64'(alloc_tag_o),   64'd1);

    // ---- same-tag collision and unallocated tag ----
    do_reset();
    tick();
    alloc_n(4);
    fma_valid_i = 1'b1; fma_tag_i = 5'd3; fma_result_i = 32'hF3;
    div_valid_i = 1'b1; div_tag_i = 5'd3; div_result_i = 32'hD3;
    check("t4_err_before", 64'(err_o), 64'd0);
    tick();
    fma_valid_i = 1'b0; div_valid_i = 1'b0;
    check("t4_coll_err", 64'(err_o), 64'd1);
    tick();
    check("t4_coll_once", 64'(err_o), 64'd0);
    cmp_valid_i = 1'b1; cmp_tag_i = 5'd9; cmp_result_i = 32'h99;
    tick();
    cmp_valid_i = 1'b0;
    check("t4_unalloc_err", 64'(err_o), 64'd1);
    fma_valid_i = 1'b1; fma_tag_i = 5'd0; fma_result_i = 32'hB0;
    div_valid_i = 1'b1; div_tag_i = 5'd1; div_result_i = 32'hB1;
    cmp_valid_i = 1'b1; cmp_tag_i = 5'd2; cmp_result_i = 32'hB2;
    tick();
    clear_inputs();
    check("t4_multi_noerr", 64'(err_o),       64'd0);
    check("t4_count_4",     64'(count_o),     64'd4);
    check("t4_r0_valid",    64'(ret_valid_o), 64'd1);
    check("t4_r0_result",   64'(ret_result_o), 64'hB0);
    ret_ready_i = 1'b1;
    tick();
    check("t4_r1_result", 64'(ret_result_o), 64'hB1);
    tick();
    check("t4_r2_result", 64'(ret_result_o), 64'hB2);
    tick();
    check("t4_r3_tag",    64'(ret_tag_o),    64'd3);
    check("t4_r3_fma_wins", 64'(ret_result_o), 64'hF3);
    tick();
    ret_ready_i = 1'b0;
    check("t4_drained", 64'(ret_valid_o), 64'd0);

    // ---- simultaneous alloc and retire at count 5 ----
    do_reset();
    tick();
    alloc_n(5);
    cmp_valid_i = 1'b1; cmp_tag_i = 5'd0; cmp_result_i = 32'hC0;
    tick();
    cmp_valid_i = 1'b0;
    check("t5_count_5_pre", 64'(count_o), 64'd5);
    alloc_valid_i = 1'b1; ret_ready_i = 1'b1;
    check("t5_alloc_tag5", 64'(alloc_tag_o), 64'd5);
    tick();
    alloc_valid_i = 1'b0; ret_ready_i = 1'b0;
    check("t5_count_5_post", 64'(count_o),     64'd5);
    check("t5_tail_adv",     64'(alloc_tag_o), 64'd6);
    check("t5_head_wait",    64'(ret_valid_o), 64'd0);
    cmp_valid_i = 1'b1; cmp_tag_i = 5'd1; cmp_result_i = 32'hC1;
    tick();
    cmp_valid_i = 1'b0;
    check("t5_head_adv",  64'(ret_tag_o),    64'd1);
    check("t5_head_data", 64'(ret_result_o), 64'hC1);

    // ---- async reset with entries in flight ----
    do_reset();
    tick();
    alloc_n(4);
    fma_valid_i = 1'b1; fma_tag_i = 5'd0; fma_result_i = 32'hE0;
    tick();
    fma_valid_i = 1'b0;
    check("t6_pre_valid", 64'(ret_valid_o), 64'd1);
    check("t6_pre_count", 64'(count_o),     64'd4);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_ready",  64'(alloc_ready_o), 64'd1);
    check("t6_rst_tag",    64'(alloc_tag_o),   64'd0);
    check("t6_rst_valid",  64'(ret_valid_o),   64'd0);
    check("t6_rst_result", 64'(ret_result_o),  64'd0);
    check("t6_rst_count",  64'(count_o),       64'd0);
    #1;
    rst_ni = 1'b1;
    div_valid_i = 1'b1; div_tag_i = 5'd1; div_result_i = 32'hDD;
    tick();
    div_valid_i = 1'b0;
    check("t6_late_err",   64'(err_o),       64'd1);
    check("t6_late_valid", 64'(ret_valid_o), 64'd0);
    check("t6_late_count", 64'(count_o),     64'd0);
    tick();
    check("t6_err_clear",  64'(err_o),       64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
